// File: rtl/note_source_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : note_source_arbiter_if
// Purpose  : Bundles the three note sources and the arbitrated tone/display
//            outputs that travel between the note producers and
//            note_source_arbiter.
// Ports    : master - note producer / consumer side. It drives the source
//                     fields and reads the arbitrated outputs.
//            slave  - arbiter side. It reads the source fields and drives
//                     the arbitrated outputs.
// Revision : 1.0  initial release
// ============================================================================
interface note_source_arbiter_if #(
  parameter int KEY_ID_BITS = 4
);
  // live keyboard scanner
  logic [KEY_ID_BITS-1:0] live_key_id;
  logic                   live_pressed;
  logic                   live_oct_up;
  logic                   live_oct_down;
  // piano_recorder playback
  logic                   rec_req;
  logic [KEY_ID_BITS-1:0] rec_key_id;
  logic                   rec_pressed;
  logic                   rec_oct_up;
  logic                   rec_oct_down;
  // song_player
  logic                   song_req;
  logic [KEY_ID_BITS-1:0] song_key_id;
  logic                   song_pressed;
  logic                   song_oct_up;
  logic                   song_oct_down;
  // arbitrated, registered outputs
  logic [KEY_ID_BITS-1:0] out_key_id;
  logic                   out_pressed;
  logic                   out_oct_up;
  logic                   out_oct_down;
  logic [1:0]             grant;
  logic                   muting;
  logic                   switch_pulse;

  modport master (
    output live_key_id, live_pressed, live_oct_up, live_oct_down,
    output rec_req, rec_key_id, rec_pressed, rec_oct_up, rec_oct_down,
    output song_req, song_key_id, song_pressed, song_oct_up, song_oct_down,
    input  out_key_id, out_pressed, out_oct_up, out_oct_down,
    input  grant, muting, switch_pulse
  );

  modport slave (
    input  live_key_id, live_pressed, live_oct_up, live_oct_down,
    input  rec_req, rec_key_id, rec_pressed, rec_oct_up, rec_oct_down,
    input  song_req, song_key_id, song_pressed, song_oct_up, song_oct_down,
    output out_key_id, out_pressed, out_oct_up, out_oct_down,
    output grant, muting, switch_pulse
  );
endinterface
`default_nettype wire

// File: rtl/note_source_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : note_source_arbiter
// Purpose  : Fixed-priority arbiter (song > recorder > live) for the shared
//            buzzer/7-seg datapath. Every ownership change goes through a
//            muted gap of GAP_CYCLES cycles, so the buzzer never glitches
//            mid-period. All outputs are registered and sanitised.
// Ports    : clk    - system clock
//            rst_n  - synchronous active-low reset
//            bus    - note_source_arbiter_if.slave. It carries the three
//                     note sources in, and out_*, grant, muting and
//                     switch_pulse out.
// Revision : 1.0  initial release
// ============================================================================
module note_source_arbiter #(
  parameter int KEY_ID_BITS = 4,
  parameter int GAP_CYCLES  = 50000,
  parameter int GAP_CNT_W   = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  note_source_arbiter_if.slave  bus
);

  // Pass-through states share the grant encoding (0 live, 1 rec, 2 song).
  typedef enum logic [1:0] {
    ST_LIVE = 2'd0,
    ST_REC  = 2'd1,
    ST_SONG = 2'd2,
    ST_MUTE = 2'd3
  } state_t;

  localparam logic [GAP_CNT_W-1:0]   GAP_LOAD = GAP_CNT_W'(GAP_CYCLES - 1);
  localparam logic [KEY_ID_BITS-1:0] MAX_NOTE = KEY_ID_BITS'(12);

  state_t                 state;
  logic [GAP_CNT_W-1:0]   gap_cnt;
  logic [1:0]             pending;
  logic [1:0]             grant_q;
  logic                   muting_q;
  logic                   pulse_q;
  logic [KEY_ID_BITS-1:0] key_q;
  logic                   pressed_q;
  logic                   oct_up_q;
  logic                   oct_down_q;

  logic [1:0]             target;
  logic [KEY_ID_BITS-1:0] raw_key;
  logic                   raw_pressed;
  logic                   raw_up;
  logic                   raw_down;
  logic [KEY_ID_BITS-1:0] san_key;
  logic                   san_pressed;
  logic                   san_up;
  logic                   san_down;

  // Whenever outputs are loaded from a source, the next owner is always the
  // current target. With no change, the target equals the owner. At the end
  // of a gap, the target equals the latched one. Sanitising the target's
  // source is therefore enough.
  always_comb begin
    target      = 2'd0;
    raw_key     = bus.live_key_id;
    raw_pressed = bus.live_pressed;
    raw_up      = bus.live_oct_up;
    raw_down    = bus.live_oct_down;
    if (bus.song_req) begin
      target      = 2'd2;
      raw_key     = bus.song_key_id;
      raw_pressed = bus.song_pressed;
      raw_up      = bus.song_oct_up;
      raw_down    = bus.song_oct_down;
    end else if (bus.rec_req) begin
      target      = 2'd1;
      raw_key     = bus.rec_key_id;
      raw_pressed = bus.rec_pressed;
      raw_up      = bus.rec_oct_up;
      raw_down    = bus.rec_oct_down;
    end
  end

  // Out-of-range IDs become a rest. A rest is never pressed. Conflicting
  // octave requests collapse to the middle octave.
  always_comb begin
    san_key     = (raw_key > MAX_NOTE) ? '0 : raw_key;
    san_pressed = raw_pressed && (raw_key != '0) && (raw_key <= MAX_NOTE);
    san_up      = raw_up & ~raw_down;
    san_down    = raw_down & ~raw_up;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_LIVE;
      gap_cnt    <= '0;
      pending    <= 2'd0;
      grant_q    <= 2'd0;
      muting_q   <= 1'b0;
      pulse_q    <= 1'b0;
      key_q      <= '0;
      pressed_q  <= 1'b0;
      oct_up_q   <= 1'b0;
      oct_down_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state)
        ST_MUTE: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else if (target == pending) begin
            state      <= state_t'(target);
            grant_q    <= target;
            muting_q   <= 1'b0;
            key_q      <= san_key;
            pressed_q  <= san_pressed;
            oct_up_q   <= san_up;
            oct_down_q <= san_down;
          end else begin
            // Requests moved during the gap: restart the gap toward the new
            // target silently.
            pending <= target;
            gap_cnt <= GAP_LOAD;
          end
        end
        default: begin
          if (target != grant_q) begin
            state      <= ST_MUTE;
            gap_cnt    <= GAP_LOAD;
            pending    <= target;
            pulse_q    <= 1'b1;
            muting_q   <= 1'b1;
            key_q      <= '0;
            pressed_q  <= 1'b0;
            oct_up_q   <= 1'b0;
            oct_down_q <= 1'b0;
          end else begin
            key_q      <= san_key;
            pressed_q  <= san_pressed;
            oct_up_q   <= san_up;
            oct_down_q <= san_down;
          end
        end
      endcase
    end
  end

  assign bus.out_key_id   = key_q;
  assign bus.out_pressed  = pressed_q;
  assign bus.out_oct_up   = oct_up_q;
  assign bus.out_oct_down = oct_down_q;
  assign bus.grant        = grant_q;
  assign bus.muting       = muting_q;
  assign bus.switch_pulse = pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_note_source_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_source_arbiter
// Purpose  : Self-checking bench for note_source_arbiter (GAP_CYCLES=4).
//            Directed scenarios are followed by randomized traffic. Every
//            cycle is compared against a behavioural ownership model.
// Revision : 1.0  initial release
// ============================================================================
module tb_note_source_arbiter;
  localparam int KB  = 4;
  localparam int GAP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  note_source_arbiter_if #(.KEY_ID_BITS(KB)) bus();

  note_source_arbiter #(
    .KEY_ID_BITS(KB),
    .GAP_CYCLES (GAP),
    .GAP_CNT_W  (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the owner, whether the arbiter is muted, how many muted
  // cycles have been spent so far, and where the gap is heading.
  int m_owner = 0;
  int m_pend  = 0;
  int m_spent = 0;
  bit m_mute  = 0;
  int e_key   = 0;
  bit e_pr = 0, e_up = 0, e_dn = 0, e_pulse = 0;

  task automatic load_expected(input int src);
    int k; bit p, u, d;
    case (src)
      2:       begin k = int'(bus.song_key_id); p = bus.song_pressed; u = bus.song_oct_up; d = bus.song_oct_down; end
      1:       begin k = int'(bus.rec_key_id);  p = bus.rec_pressed;  u = bus.rec_oct_up;  d = bus.rec_oct_down;  end
      default: begin k = int'(bus.live_key_id); p = bus.live_pressed; u = bus.live_oct_up; d = bus.live_oct_down; end
    endcase
    e_key = (k >= 1 && k <= 12) ? k : 0;
    e_pr  = p && (k >= 1 && k <= 12);
    e_up  = u && !d;
    e_dn  = d && !u;
  endtask

  task automatic model_step();
    int tgt;
    e_pulse = 0;
    if (!rst_n) begin
      m_owner = 0; m_mute = 0; m_spent = 0; m_pend = 0;
      e_key = 0; e_pr = 0; e_up = 0; e_dn = 0;
      return;
    end
    tgt = bus.song_req ? 2 : (bus.rec_req ? 1 : 0);
    if (!m_mute) begin
      if (tgt != m_owner) begin
        m_mute = 1; m_spent = 1; m_pend = tgt; e_pulse = 1;
        e_key = 0; e_pr = 0; e_up = 0; e_dn = 0;
      end else begin
        load_expected(m_owner);
      end
    end else if (m_spent < GAP) begin
      m_spent++;
    end else if (tgt == m_pend) begin
      m_mute = 0; m_owner = tgt;
      load_expected(tgt);
    end else begin
      m_pend = tgt; m_spent = 1;
    end
  endtask

  // One clock: predict from the inputs about to be sampled, then compare.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("out_key_id",   32'(bus.out_key_id),   32'(e_key));
    check("out_pressed",  32'(bus.out_pressed),  32'(e_pr));
    check("out_oct_up",   32'(bus.out_oct_up),   32'(e_up));
    check("out_oct_down", 32'(bus.out_oct_down), 32'(e_dn));
    check("grant",        32'(bus.grant),        32'(m_owner));
    check("muting",       32'(bus.muting),       32'(m_mute));
    check("switch_pulse", 32'(bus.switch_pulse), 32'(e_pulse));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic rand_data();
    bus.live_key_id = KB'($urandom_range(15));
    bus.rec_key_id  = KB'($urandom_range(15));
    bus.song_key_id = KB'($urandom_range(15));
    {bus.live_pressed, bus.live_oct_up, bus.live_oct_down} = 3'($urandom);
    {bus.rec_pressed,  bus.rec_oct_up,  bus.rec_oct_down}  = 3'($urandom);
    {bus.song_pressed, bus.song_oct_up, bus.song_oct_down} = 3'($urandom);
  endtask

  int pulses;

  initial begin
    bus.live_key_id = 4'd5; bus.live_pressed = 1'b1; bus.live_oct_up = 1'b0; bus.live_oct_down = 1'b0;
    bus.rec_req = 1'b0; bus.rec_key_id = 4'd7; bus.rec_pressed = 1'b1; bus.rec_oct_up = 1'b0; bus.rec_oct_down = 1'b0;
    bus.song_req = 1'b0; bus.song_key_id = 4'd3; bus.song_pressed = 1'b1; bus.song_oct_up = 1'b1; bus.song_oct_down = 1'b0;

    // Reset, then live pass-through
    rst_n = 1'b0;
    cycle();
    check("reset_key", 32'(bus.out_key_id), 32'd0);
    check("reset_grant", 32'(bus.grant), 32'd0);
    rst_n = 1'b1;
    cycle();
    check("t1_key", 32'(bus.out_key_id), 32'd5);
    check("t1_pressed", 32'(bus.out_pressed), 32'd1);
    check("t1_grant", 32'(bus.grant), 32'd0);

    // Song preempts live
    bus.song_req = 1'b1;
    cycle();
    check("t2_pulse", 32'(bus.switch_pulse), 32'd1);
    cycles(3);
    check("t2_muted_key", 32'(bus.out_key_id), 32'd0);
    check("t2_still_muting", 32'(bus.muting), 32'd1);
    cycle();
    check("t2_grant", 32'(bus.grant), 32'd2);
    check("t2_key", 32'(bus.out_key_id), 32'd3);

    // Recorder owns, song preempts, song drops back to recorder
    bus.song_req = 1'b0; bus.rec_req = 1'b1;
    cycles(6);
    check("t3_rec_grant", 32'(bus.grant), 32'd1);
    bus.song_req = 1'b1;
    cycles(5);
    check("t3_song_grant", 32'(bus.grant), 32'd2);
    bus.song_req = 1'b0;
    cycles(5);
    check("t3_back_rec", 32'(bus.grant), 32'd1);

    // Back to live, then a short rec pulse during the gap
    bus.rec_req = 1'b0;
    cycles(6);
    check("t4_live", 32'(bus.grant), 32'd0);
    pulses = 0;
    bus.rec_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) bus.rec_req = 1'b0;
      cycle();
      if (bus.switch_pulse) pulses++;
    end
    check("t4_pulses", 32'(pulses), 32'd1);
    check("t4_grant", 32'(bus.grant), 32'd0);
    check("t4_muting", 32'(bus.muting), 32'd0);

    // Sanitising
    bus.live_key_id = 4'd13;
    cycle();
    check("t5_key13", 32'(bus.out_key_id), 32'd0);
    check("t5_pressed13", 32'(bus.out_pressed), 32'd0);
    bus.live_key_id = 4'd4; bus.live_oct_up = 1'b1; bus.live_oct_down = 1'b1;
    cycle();
    check("t5_up", 32'(bus.out_oct_up), 32'd0);
    check("t5_down", 32'(bus.out_oct_down), 32'd0);
    check("t5_key4", 32'(bus.out_key_id), 32'd4);

    // Reset mid-gap toward song
    bus.song_req = 1'b1;
    cycles(2);
    rst_n = 1'b0;
    cycle();
    check("t6_key", 32'(bus.out_key_id), 32'd0);
    check("t6_grant", 32'(bus.grant), 32'd0);
    check("t6_muting", 32'(bus.muting), 32'd0);
    rst_n = 1'b1;
    cycle();
    check("t6_pulse", 32'(bus.switch_pulse), 32'd1);
    check("t6_muting2", 32'(bus.muting), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rand_data();
      if ($urandom_range(15) == 0) bus.song_req = ~bus.song_req;
      if ($urandom_range(11) == 0) bus.rec_req = ~bus.rec_req;
      rst_n = ($urandom_range(299) == 0) ? 1'b0 : 1'b1;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
